// File: rtl/controle_instr.sv
// Instruction sequencer: decodes a 16-bit word, reads the source register,
// drives the downstream ALU for one cycle and writes its result back.
module controle_instr (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [15:0] instr,
    input  logic        instr_valid,
    output logic        instr_ready,
    input  logic [6:0]  alu_q,
    output logic [6:0]  op1,
    output logic [6:0]  op2,
    output logic [2:0]  opcode,
    output logic        done,
    output logic        illegal,
    output logic [7:0]  instr_count,
    input  logic [2:0]  dbg_addr,
    output logic [6:0]  dbg_data
);

    localparam int unsigned DATA_W  = 7;
    localparam int unsigned ADDR_W  = 3;
    localparam int unsigned OPC_W   = 3;
    localparam int unsigned REG_N   = 8;
    localparam int unsigned CNT_W   = 8;

    localparam logic [OPC_W-1:0] OPC_LOAD = 3'b000;
    localparam logic [OPC_W-1:0] OPC_ADD  = 3'b010;
    localparam logic [OPC_W-1:0] OPC_SUB  = 3'b100;
    localparam logic [OPC_W-1:0] OPC_MUL  = 3'b101;

    typedef struct packed {
        logic [OPC_W-1:0]  opc;
        logic [ADDR_W-1:0] rd;
        logic [ADDR_W-1:0] rs;
        logic [DATA_W-1:0] imm;
    } instr_t;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EXEC = 2'd1,
        ST_WB   = 2'd2
    } state_e;

    state_e                        state_q, state_d;
    logic [REG_N-1:0][DATA_W-1:0]  rf_q, rf_d;
    logic [DATA_W-1:0]             op1_q, op1_d;
    logic [DATA_W-1:0]             op2_q, op2_d;
    logic [OPC_W-1:0]              opcode_q, opcode_d;
    logic [ADDR_W-1:0]             rd_q, rd_d;
    logic                          done_q, done_d;
    logic                          illegal_q, illegal_d;
    logic [CNT_W-1:0]              count_q, count_d;

    instr_t                        instr_s;
    logic                          legal_c;
    logic [DATA_W-1:0]             rs_val_c;

    assign instr_s = instr_t'(instr);

    // Opcode legality decode
    always_comb begin
        legal_c = 1'b0;
        case (instr_s.opc)
            OPC_LOAD, OPC_ADD, OPC_SUB, OPC_MUL: legal_c = 1'b1;
            default:                             legal_c = 1'b0;
        endcase
    end

    // r0 is hard-wired to zero on every read port
    assign rs_val_c = (instr_s.rs == ADDR_W'(0)) ? DATA_W'(0) : rf_q[instr_s.rs];
    assign dbg_data = (dbg_addr == ADDR_W'(0)) ? DATA_W'(0) : rf_q[dbg_addr];

    // Next-state, operand capture, writeback and counter
    always_comb begin
        state_d   = state_q;
        rf_d      = rf_q;
        op1_d     = op1_q;
        op2_d     = op2_q;
        opcode_d  = opcode_q;
        rd_d      = rd_q;
        done_d    = 1'b0;
        illegal_d = 1'b0;
        count_d   = count_q;

        case (state_q)
            ST_IDLE: begin
                if (instr_valid) begin
                    if (legal_c) begin
                        opcode_d = instr_s.opc;
                        op2_d    = instr_s.imm;
                        op1_d    = rs_val_c;
                        rd_d     = instr_s.rd;
                        state_d  = ST_EXEC;
                    end else begin
                        illegal_d = 1'b1;
                    end
                end
            end
            ST_EXEC: begin
                // done is a registered pulse covering the WB cycle
                done_d  = 1'b1;
                state_d = ST_WB;
            end
            ST_WB: begin
                if (rd_q != ADDR_W'(0)) begin
                    rf_d[rd_q] = alu_q;
                end
                count_d = count_q + CNT_W'(1);
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= ST_IDLE;
            rf_q      <= '0;
            op1_q     <= '0;
            op2_q     <= '0;
            opcode_q  <= '0;
            rd_q      <= '0;
            done_q    <= 1'b0;
            illegal_q <= 1'b0;
            count_q   <= '0;
        end else begin
            state_q   <= state_d;
            rf_q      <= rf_d;
            op1_q     <= op1_d;
            op2_q     <= op2_d;
            opcode_q  <= opcode_d;
            rd_q      <= rd_d;
            done_q    <= done_d;
            illegal_q <= illegal_d;
            count_q   <= count_d;
        end
    end

    assign instr_ready = (state_q == ST_IDLE);
    assign op1         = op1_q;
    assign op2         = op2_q;
    assign opcode      = opcode_q;
    assign done        = done_q;
    assign illegal     = illegal_q;
    assign instr_count = count_q;

endmodule
